// File: rtl/prog_mem_pkg.sv
// Shared state encodings, default widths and pointer helper for the program memory controller.
package prog_mem_pkg;

   localparam int DEFAULT_NUM_CONSUMERS = 4;
   localparam int DEFAULT_ADDR_BITS     = 8;
   localparam int DEFAULT_DATA_BITS     = 32;

   typedef enum logic [1:0] {
      IDLE         = 2'b00,
      READ_WAITING = 2'b01,
      RELAYING     = 2'b10
   } state_t;

   function automatic int unsigned wrap_inc(input int unsigned value, input int unsigned modulus);
      return (value + 1 >= modulus) ? 0 : value + 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requesting channel at or after ptr, wrapping.
module rr_arbiter #(
   parameter int NUM_CONSUMERS = 4,
   parameter int PTR_BITS      = 2
) (
   input  logic [NUM_CONSUMERS-1:0] req,
   input  logic [PTR_BITS-1:0]      ptr,
   output logic [NUM_CONSUMERS-1:0] grant_onehot,
   output logic [PTR_BITS-1:0]      grant_idx
);

   logic                found;
   logic [PTR_BITS-1:0] idx;

   always_comb begin
      grant_onehot = '0;
      grant_idx    = '0;
      found        = 1'b0;
      idx          = '0;
      for (int off = 0; off < NUM_CONSUMERS; off++) begin
         idx = PTR_BITS'((int'(ptr) + off) % NUM_CONSUMERS);
         if (!found && req[idx]) begin
            found             = 1'b1;
            grant_onehot[idx] = 1'b1;
            grant_idx         = idx;
         end
      end
   end

endmodule

// File: rtl/program_mem_controller.sv
// Shares one program memory read port among NUM_CONSUMERS fetchers, one read outstanding.
// Define PROG_MEM_BROADCAST_EN to also serve other waiting channels that requested the same address.
module program_mem_controller
   import prog_mem_pkg::*;
#(
   parameter int NUM_CONSUMERS = DEFAULT_NUM_CONSUMERS,
   parameter int ADDR_BITS     = DEFAULT_ADDR_BITS,
   parameter int DATA_BITS     = DEFAULT_DATA_BITS
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
   input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
   output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
   output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
   output logic                               mem_read_valid,
   output logic [ADDR_BITS-1:0]               mem_read_address,
   input  logic                               mem_read_ready,
   input  logic [DATA_BITS-1:0]               mem_read_data,
   output logic                               busy
);

   localparam int PTR_BITS = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

   state_t                     state_reg;
   logic [PTR_BITS-1:0]        rr_ptr_reg;
   logic [PTR_BITS-1:0]        grant_id_reg;
   logic                       mem_read_valid_reg;
   logic [ADDR_BITS-1:0]       mem_read_address_reg;
   logic [NUM_CONSUMERS-1:0]   ready_reg;
   logic [NUM_CONSUMERS-1:0]   ready_next;
   logic [NUM_CONSUMERS-1:0]   serve_vec;
   logic [NUM_CONSUMERS-1:0]   grant_sel;
   logic [NUM_CONSUMERS-1:0]   bcast_match;
   logic [NUM_CONSUMERS-1:0]   arb_onehot;
   logic [PTR_BITS-1:0]        arb_idx;
   logic                       response_edge;
   logic [ADDR_BITS-1:0]       addr_slice [NUM_CONSUMERS];
   logic [DATA_BITS-1:0]       data_reg   [NUM_CONSUMERS];

   rr_arbiter #(
      .NUM_CONSUMERS(NUM_CONSUMERS),
      .PTR_BITS     (PTR_BITS)
   ) u_rr_arbiter (
      .req         (consumer_read_valid),
      .ptr         (rr_ptr_reg),
      .grant_onehot(arb_onehot),
      .grant_idx   (arb_idx)
   );

   generate
      for (genvar gi = 0; gi < NUM_CONSUMERS; gi++) begin : g_chan
         assign addr_slice[gi] = consumer_read_address[gi*ADDR_BITS +: ADDR_BITS];
         assign grant_sel[gi]  = (grant_id_reg == PTR_BITS'(gi));
`ifdef PROG_MEM_BROADCAST_EN
         assign bcast_match[gi] = consumer_read_valid[gi] && (addr_slice[gi] == mem_read_address_reg);
`else
         assign bcast_match[gi] = 1'b0;
`endif
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               data_reg[gi] <= '0;
            end else if (serve_vec[gi]) begin
               data_reg[gi] <= mem_read_data;
            end
         end
         assign consumer_read_data[gi*DATA_BITS +: DATA_BITS] = data_reg[gi];
      end
   endgenerate

   // The granted channel is served even if it already withdrew its request.
   assign response_edge = (state_reg == READ_WAITING) && mem_read_ready;
   assign serve_vec     = response_edge ? (grant_sel | bcast_match) : '0;
   assign ready_next    = (ready_reg & consumer_read_valid) | serve_vec;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg            <= IDLE;
         rr_ptr_reg           <= '0;
         grant_id_reg         <= '0;
         mem_read_valid_reg   <= 1'b0;
         mem_read_address_reg <= '0;
         ready_reg            <= '0;
      end else begin
         ready_reg <= ready_next;
         case (state_reg)
            IDLE: begin
               if (|arb_onehot) begin
                  mem_read_address_reg <= addr_slice[arb_idx];
                  mem_read_valid_reg   <= 1'b1;
                  grant_id_reg         <= arb_idx;
                  rr_ptr_reg           <= PTR_BITS'(wrap_inc(32'(arb_idx), NUM_CONSUMERS));
                  state_reg            <= READ_WAITING;
               end
            end
            READ_WAITING: begin
               if (mem_read_ready) begin
                  mem_read_valid_reg <= 1'b0;
                  state_reg          <= RELAYING;
               end
            end
            RELAYING: begin
               if (ready_next == '0) begin
                  state_reg <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign consumer_read_ready = ready_reg;
   assign mem_read_valid      = mem_read_valid_reg;
   assign mem_read_address    = mem_read_address_reg;
   assign busy                = (state_reg != IDLE);

endmodule

// File: tb/tb_program_mem_controller.sv
// Directed self-checking bench for program_mem_controller (4 channels, 8-bit address, 32-bit data).
module tb_program_mem_controller;

   localparam int N  = 4;
   localparam int AB = 8;
   localparam int DB = 32;

   logic              clk = 1'b0;
   logic              reset;
   logic [N-1:0]      valid;
   logic [N*AB-1:0]   addr;
   logic [N-1:0]      ready;
   logic [N*DB-1:0]   rdata;
   logic              mem_valid;
   logic [AB-1:0]     mem_addr;
   logic              mem_ready;
   logic [DB-1:0]     mem_data;
   logic              busy;

   int n_checks  = 0;
   int n_errors  = 0;
   int txn_count = 0;
   int txn_start;

   always #5 clk = ~clk;

   program_mem_controller dut (
      .clk                  (clk),
      .reset                (reset),
      .consumer_read_valid  (valid),
      .consumer_read_address(addr),
      .consumer_read_ready  (ready),
      .consumer_read_data   (rdata),
      .mem_read_valid       (mem_valid),
      .mem_read_address     (mem_addr),
      .mem_read_ready       (mem_ready),
      .mem_read_data        (mem_data),
      .busy                 (busy)
   );

   always @(posedge clk) begin
      if (mem_valid && mem_ready) txn_count <= txn_count + 1;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_addr(input int ch, input logic [AB-1:0] a);
      addr[ch*AB +: AB] = a;
   endtask

   function automatic logic [DB-1:0] data_of(input int ch);
      return rdata[ch*DB +: DB];
   endfunction

   task automatic do_reset();
      valid     = '0;
      mem_ready = 1'b0;
      reset     = 1'b0;
      step();
      step();
      reset = 1'b1;
   endtask

   // Full standard fetch: grant, zero-wait response, fetcher drops valid, ready clears.
   task automatic fetch(input int ch, input logic [AB-1:0] exp_addr, input logic [DB-1:0] d);
      step();
      check("grant_mem_valid", 64'(mem_valid), 64'(1));
      check("grant_mem_addr", 64'(mem_addr), 64'(exp_addr));
      check("grant_ready_low", 64'(ready), 64'(0));
      mem_ready = 1'b1;
      mem_data  = d;
      step();
      mem_ready = 1'b0;
      check("resp_ready", 64'(ready), 64'(1) << ch);
      check("resp_data", 64'(data_of(ch)), 64'(d));
      check("resp_mem_valid_low", 64'(mem_valid), 64'(0));
      step();
      check("relay_ready_held", 64'(ready), 64'(1) << ch);
      valid[ch] = 1'b0;
      step();
      check("relay_ready_clear", 64'(ready), 64'(0));
      check("relay_idle", 64'(busy), 64'(0));
   endtask

   initial begin
      reset     = 1'b0;
      valid     = '0;
      addr      = '0;
      mem_ready = 1'b0;
      mem_data  = '0;
      #2;
      check("rst_mem_valid", 64'(mem_valid), 64'(0));
      check("rst_mem_addr", 64'(mem_addr), 64'(0));
      check("rst_ready", 64'(ready), 64'(0));
      check("rst_data0", 64'(data_of(0)), 64'(0));
      check("rst_busy", 64'(busy), 64'(0));
      step();
      step();
      reset = 1'b1;

      // Single fetch with a two-cycle memory response
      set_addr(0, 8'h12);
      valid[0] = 1'b1;
      step();
      check("single_mem_valid", 64'(mem_valid), 64'(1));
      check("single_mem_addr", 64'(mem_addr), 64'(8'h12));
      check("single_busy", 64'(busy), 64'(1));
      step();
      check("single_wait_ready", 64'(ready), 64'(0));
      mem_ready = 1'b1;
      mem_data  = 32'hDEADBEEF;
      step();
      mem_ready = 1'b0;
      check("single_ready", 64'(ready), 64'(4'b0001));
      check("single_data", 64'(data_of(0)), 64'(32'hDEADBEEF));
      check("single_other_slice", 64'(data_of(1)), 64'(0));
      step();
      check("single_ready_held", 64'(ready), 64'(4'b0001));
      valid[0] = 1'b0;
      step();
      check("single_ready_clear", 64'(ready), 64'(0));
      check("single_idle", 64'(busy), 64'(0));

      // Fairness: all channels request continuously
      do_reset();
      for (int i = 0; i < N; i++) set_addr(i, 8'h20 + 8'(i));
      valid = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         fetch(i % N, 8'h20 + 8'(i % N), 32'hA000_0000 + 32'(i));
         valid[i % N] = 1'b1;
      end
      valid = '0;
      check("fair_slice1_held", 64'(data_of(1)), 64'(32'hA000_0001));
      step();

      // Memory stall: 20 cycles without a response (rr_ptr is 1 here)
      set_addr(1, 8'h77);
      valid[1] = 1'b1;
      step();
      for (int i = 0; i < 20; i++) begin
         step();
         check("stall_stable", {mem_valid, ready, mem_addr}, {1'b1, 4'b0000, 8'h77});
      end
      mem_ready = 1'b1;
      mem_data  = 32'hCAFEF00D;
      step();
      mem_ready = 1'b0;
      check("stall_ready", 64'(ready), 64'(4'b0010));
      check("stall_data", 64'(data_of(1)), 64'(32'hCAFEF00D));
      step();
      valid[1] = 1'b0;
      step();
      check("stall_idle", 64'(busy), 64'(0));

      // Reset asserted while the read is outstanding
      set_addr(3, 8'h55);
      valid[3] = 1'b1;
      step();
      check("rstmid_mem_addr", 64'(mem_addr), 64'(8'h55));
      step();
      #2;
      reset = 1'b0;
      valid = '0;
      #1;
      check("rstmid_mem_valid", 64'(mem_valid), 64'(0));
      check("rstmid_mem_addr0", 64'(mem_addr), 64'(0));
      check("rstmid_busy", 64'(busy), 64'(0));
      check("rstmid_data1", 64'(data_of(1)), 64'(0));
      @(posedge clk);
      #1;
      reset     = 1'b1;
      mem_ready = 1'b1;
      mem_data  = 32'hBAD0BAD0;
      step();
      mem_ready = 1'b0;
      check("rstmid_late_ready", 64'(ready), 64'(0));
      check("rstmid_late_data", 64'(data_of(3)), 64'(0));
      check("rstmid_late_busy", 64'(busy), 64'(0));

      // Withdrawn request on channel 2
      set_addr(2, 8'h33);
      valid[2] = 1'b1;
      step();
      check("withdraw_mem_addr", 64'(mem_addr), 64'(8'h33));
      valid[2] = 1'b0;
      step();
      check("withdraw_busy", 64'(busy), 64'(1));
      mem_ready = 1'b1;
      mem_data  = 32'h12345678;
      step();
      mem_ready = 1'b0;
      check("withdraw_ready", 64'(ready), 64'(4'b0100));
      check("withdraw_data", 64'(data_of(2)), 64'(32'h12345678));
      step();
      check("withdraw_ready_clear", 64'(ready), 64'(0));
      check("withdraw_idle", 64'(busy), 64'(0));

      // Shared address on channels 1 and 3
      do_reset();
      set_addr(1, 8'h40);
      set_addr(2, 8'h41);
      set_addr(3, 8'h40);
      valid     = 4'b1110;
      txn_start = txn_count;
`ifdef PROG_MEM_BROADCAST_EN
      step();
      check("bcast_mem_addr", 64'(mem_addr), 64'(8'h40));
      mem_ready = 1'b1;
      mem_data  = 32'h11111111;
      step();
      mem_ready = 1'b0;
      check("bcast_ready", 64'(ready), 64'(4'b1010));
      check("bcast_data3", 64'(data_of(3)), 64'(32'h11111111));
      check("bcast_data2", 64'(data_of(2)), 64'(0));
      step();
      valid[1] = 1'b0;
      valid[3] = 1'b0;
      step();
      check("bcast_ready_clear", 64'(ready), 64'(0));
      fetch(2, 8'h41, 32'h22222222);
      step();
      check("bcast_txns", 64'(txn_count - txn_start), 64'(2));
`else
      fetch(1, 8'h40, 32'h11111111);
      fetch(2, 8'h41, 32'h22222222);
      fetch(3, 8'h40, 32'h33333333);
      step();
      check("bcast_txns", 64'(txn_count - txn_start), 64'(3));
`endif
      check("final_idle", 64'(busy), 64'(0));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/program_mem_controller.md
# program_mem_controller

Shares the single read-only program memory port between `NUM_CONSUMERS` instruction fetchers, one per core. It arbitrates round-robin, keeps one memory read outstanding at a time, and relays each response back to the requesting fetcher. It sits between the per-core fetchers and the program memory. Both sides use the same valid/ready read handshake the fetchers already drive.

## Interface
- `NUM_CONSUMERS`, 4: number of fetcher channels (≥1).
- `ADDR_BITS`, 8: program memory address width.
- `DATA_BITS`, 32: instruction width.
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `consumer_read_valid`  in  NUM_CONSUMERS  per-fetcher request; held high until that fetcher sees its ready.
- `consumer_read_address`  in  NUM_CONSUMERS*ADDR_BITS  packed; slice i belongs to fetcher i.
- `consumer_read_ready`  out  NUM_CONSUMERS  response valid for fetcher i.
- `consumer_read_data`  out  NUM_CONSUMERS*DATA_BITS  packed per-fetcher instruction.
- `mem_read_valid`  out  1  request to program memory.
- `mem_read_address`  out  ADDR_BITS  request address.
- `mem_read_ready`  in  1  memory response strobe.
- `mem_read_data`  in  DATA_BITS  memory response data.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- The FSM has three states: IDLE, READ_WAITING and RELAYING. Registered round-robin pointer `rr_ptr`; `grant_id` holds the selected channel.
- **IDLE:**
  - If any `consumer_read_valid` bit is set, select the first valid channel at or after `rr_ptr`, wrapping modulo NUM_CONSUMERS.
  - Register `mem_read_address` from that slice and set `mem_read_valid`=1.
  - Set `rr_ptr` = grant+1 mod N, then go to READ_WAITING.
- **READ_WAITING:**
  - `mem_read_valid` and `mem_read_address` are held stable.
  - On `mem_read_ready`, latch `mem_read_data` into slice `grant_id` of `consumer_read_data`.
  - Set `consumer_read_ready[grant_id]`=1 and `mem_read_valid`=0, then go to RELAYING.
- **RELAYING:**
  - Each asserted ready bit clears on the first edge where its `consumer_read_valid` bit is sampled low.
  - When all ready bits are clear, return to IDLE.
- `mem_read_ready` is ignored outside READ_WAITING.
- Data slices not being written hold their previous value.
- A fetcher that drops valid during READ_WAITING is a protocol violation. The memory read still completes, ready is asserted for exactly one cycle, and the FSM returns to IDLE.
- Any assertion of `reset` clears all state regardless of FSM state. An in-flight memory response is abandoned, and a `mem_read_ready` arriving after release while in IDLE is ignored.

## Timing
- Reset values:
  - FSM = IDLE, `rr_ptr`=0.
  - `mem_read_valid`=0, `mem_read_address`=0.
  - All `consumer_read_ready`=0, all `consumer_read_data`=0, `busy`=0.
- Request latency: `consumer_read_valid` sampled at edge t gives `mem_read_valid` high after edge t.
- Response latency: `mem_read_ready` sampled at edge k gives `consumer_read_ready` and data visible after edge k.
- With a standard fetcher, valid drops after edge k+1, ready clears at edge k+2, and the FSM is in IDLE after edge k+2. The next grant is issued at edge k+3.
- With zero memory wait, the minimum turnaround is 4 cycles per fetch.

## Configuration
- Macro `PROG_MEM_BROADCAST_EN`.
- **Defined:** on the `mem_read_ready` edge, every other channel whose valid is high and whose address slice equals `mem_read_address` also latches the data and asserts ready. RELAYING waits for all of these channels. `rr_ptr` still advances only past `grant_id`.
- **Undefined:** only `grant_id` is served.

## Structure
- Shared package/header `prog_mem_pkg` holds the state encodings IDLE=2'b00, READ_WAITING=2'b01 and RELAYING=2'b10, plus the default width constants.
- One sub-module, `rr_arbiter`: it takes the request vector and pointer and returns the one-hot grant and grant index. It is purely combinational; the controller owns the pointer register.

## Test plan
- **Single fetch:** ch0 requests addr 0x12 and memory answers 2 cycles later with 0xDEADBEEF. `mem_read_address`=0x12 one cycle after the request; `consumer_read_data[0]`=0xDEADBEEF together with ready; ready clears one cycle after valid drops.
- **Fairness:** all 4 channels request at once after reset, each re-requesting immediately after being served. Grants go 0,1,2,3,0; no channel is served twice before the others.
- **Broadcast:** ch1 and ch3 request addr 0x40 and ch2 requests addr 0x41. With `PROG_MEM_BROADCAST_EN` this takes 2 memory transactions, with ch1 and ch3 readied on the same cycle; without it, 3 transactions.
- **Memory stall:** `mem_read_ready` is held low for 20 cycles. `mem_read_valid` and the address stay stable and no `consumer_read_ready` is asserted.
- **Reset mid-read:** `reset` is taken low during READ_WAITING. All outputs go to their reset values immediately; a `mem_read_ready` after release produces no ready.
- **Withdrawn request:** ch2 drops valid during READ_WAITING. `consumer_read_ready[2]` is high for exactly one cycle, then the FSM is in IDLE.
